// File: rtl/i2c_target_rx_if.sv
// Bus-side and receive-side signals of the I2C write-only target receiver.
`timescale 1ns/1ps
interface i2c_target_rx_if;
  logic       scl;
  logic       sda_in;
  logic       sda_oe;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       busy;
  logic       addr_match;

  modport master (
    output scl, sda_in,
    input  sda_oe, rx_data, rx_valid, busy, addr_match
  );

  modport slave (
    input  scl, sda_in,
    output sda_oe, rx_data, rx_valid, busy, addr_match
  );
endinterface

// File: rtl/i2c_target_rx.sv
// Write-only I2C target: oversampled SCL/SDA, START/STOP detection, 7-bit
// address match, ACK generation and one-cycle strobe per received byte.
`timescale 1ns/1ps
module i2c_target_rx #(
  parameter logic [6:0] SLAVE_ADDR = 7'h27
) (
  input  logic            clk,
  input  logic            reset_p,
  i2c_target_rx_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ACK_ADDR,
    DATA,
    ACK_DATA,
    IGNORE
  } state_t;

  state_t     state;
  logic [1:0] scl_sync;
  logic [1:0] sda_sync;
  logic       scl_prev;
  logic       sda_prev;
  logic [7:0] shift;
  logic [3:0] bit_cnt;
  logic       sda_oe_r;
  logic [7:0] rx_data_r;
  logic       rx_valid_r;
  logic       addr_match_r;

  logic scl_s, sda_s;
  logic scl_rise, scl_fall, sda_rise, sda_fall;
  logic start_det, stop_det;

  // Synchronizers and previous-value registers idle high like the bus.
  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_prev <= 1'b1;
      sda_prev <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[0], bus.scl};
      sda_sync <= {sda_sync[0], bus.sda_in};
      scl_prev <= scl_sync[1];
      sda_prev <= sda_sync[1];
    end
  end

  assign scl_s     = scl_sync[1];
  assign sda_s     = sda_sync[1];
  assign scl_rise  = scl_s & ~scl_prev;
  assign scl_fall  = ~scl_s & scl_prev;
  assign sda_rise  = sda_s & ~sda_prev;
  assign sda_fall  = ~sda_s & sda_prev;
  assign start_det = sda_fall & scl_s;
  assign stop_det  = sda_rise & scl_s;

  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      state        <= IDLE;
      shift        <= '0;
      bit_cnt      <= '0;
      sda_oe_r     <= 1'b0;
      rx_data_r    <= '0;
      rx_valid_r   <= 1'b0;
      addr_match_r <= 1'b0;
    end else begin
      rx_valid_r <= 1'b0;
      if (start_det) begin
        state        <= ADDR;
        shift        <= '0;
        bit_cnt      <= '0;
        sda_oe_r     <= 1'b0;
        addr_match_r <= 1'b0;
      end else if (stop_det) begin
        state        <= IDLE;
        shift        <= '0;
        bit_cnt      <= '0;
        sda_oe_r     <= 1'b0;
        addr_match_r <= 1'b0;
      end else begin
        case (state)
          IDLE: ;
          ADDR, DATA: begin
            // Counter parks at 8 so extra rising edges never reach the ACK slot.
            if (scl_rise && bit_cnt != 4'd8) begin
              shift   <= {shift[6:0], sda_s};
              bit_cnt <= bit_cnt + 4'd1;
            end else if (scl_fall && bit_cnt == 4'd8) begin
              if (state == ADDR) begin
                if (shift[7:1] == SLAVE_ADDR && !shift[0]) begin
                  sda_oe_r     <= 1'b1;
                  addr_match_r <= 1'b1;
                  state        <= ACK_ADDR;
                end else begin
                  sda_oe_r <= 1'b0;
                  state    <= IGNORE;
                end
              end else begin
                rx_data_r  <= shift;
                rx_valid_r <= 1'b1;
                sda_oe_r   <= 1'b1;
                state      <= ACK_DATA;
              end
            end
          end
          ACK_ADDR, ACK_DATA: begin
            if (scl_fall) begin
              sda_oe_r <= 1'b0;
              bit_cnt  <= '0;
              state    <= DATA;
            end
          end
          IGNORE:  sda_oe_r <= 1'b0;
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.sda_oe     = sda_oe_r;
  assign bus.rx_data    = rx_data_r;
  assign bus.rx_valid   = rx_valid_r;
  assign bus.addr_match = addr_match_r;
  assign bus.busy       = (state != IDLE);

endmodule

// File: tb/tb_i2c_target_rx.sv
// Directed plus randomized bench for i2c_target_rx, driving a bit-level I2C master.
`timescale 1ns/1ps
module tb_i2c_target_rx;
  localparam logic [6:0] SLAVE_ADDR = 7'h27;
  localparam time T = 100ns;

  logic clk = 1'b0;
  logic reset_p = 1'b1;
  logic scl_m = 1'b1;
  logic sda_m = 1'b1;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  logic [7:0] rx_q[$];
  logic [7:0] tx_q[$];
  logic [7:0] exp_rx_data = 8'h00;

  i2c_target_rx_if bus ();

  // Open-drain wired-AND of master drive and target ACK pull-down.
  assign bus.scl    = scl_m;
  assign bus.sda_in = sda_m & ~bus.sda_oe;

  i2c_target_rx #(.SLAVE_ADDR(SLAVE_ADDR)) dut (
    .clk     (clk),
    .reset_p (reset_p),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.rx_valid) rx_q.push_back(bus.rx_data);
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic i2c_start();
    sda_m = 1'b0; #T;
    scl_m = 1'b0; #T;
  endtask

  task automatic i2c_rstart();
    sda_m = 1'b1; #T;
    scl_m = 1'b1; #T;
    sda_m = 1'b0; #T;
    scl_m = 1'b0; #T;
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; #T;
    scl_m = 1'b1; #T;
    sda_m = 1'b1;
  endtask

  task automatic write_bit(input logic b);
    sda_m = b; #T;
    scl_m = 1'b1; #(2*T);
    scl_m = 1'b0; #T;
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) write_bit(b[i]);
    sda_m = 1'b1; #T;
    scl_m = 1'b1; #T;
    ack = bus.sda_oe;
    #T;
    scl_m = 1'b0; #T;
  endtask

  // Reference: the target ACKs only its own address with the write bit, then
  // every complete byte; anything else is ignored until the next START/STOP.
  task automatic xfer(input logic [7:0] addr, input string tag);
    logic       ack;
    logic       acked;
    logic [7:0] exp_q[$];
    acked = (addr == {SLAVE_ADDR, 1'b0});
    rx_q.delete();
    i2c_start();
    write_byte(addr, ack);
    check({tag, ".addr_ack"}, ack, acked);
    foreach (tx_q[i]) begin
      write_byte(tx_q[i], ack);
      check({tag, ".data_ack"}, ack, acked);
      if (acked) begin
        exp_q.push_back(tx_q[i]);
        exp_rx_data = tx_q[i];
      end
    end
    check({tag, ".addr_match"}, bus.addr_match, acked);
    check({tag, ".busy_pre_stop"}, bus.busy, 1'b1);
    i2c_stop();
    repeat (4) @(posedge clk);
    #1;
    check({tag, ".busy_post_stop"}, bus.busy, 1'b0);
    check({tag, ".addr_match_post_stop"}, bus.addr_match, 1'b0);
    check({tag, ".rx_count"}, rx_q.size(), exp_q.size());
    foreach (exp_q[i])
      if (i < rx_q.size()) check({tag, ".rx_byte"}, rx_q[i], exp_q[i]);
    check({tag, ".rx_data"}, bus.rx_data, exp_rx_data);
    #T;
  endtask

  initial begin
    logic       ack;
    logic [7:0] b;

    #23;
    check("reset.sda_oe", bus.sda_oe, 1'b0);
    check("reset.rx_data", bus.rx_data, 8'h00);
    check("reset.rx_valid", bus.rx_valid, 1'b0);
    check("reset.busy", bus.busy, 1'b0);
    check("reset.addr_match", bus.addr_match, 1'b0);
    reset_p = 1'b0;
    #T;

    tx_q = '{8'hA5};
    xfer(8'h4E, "t1_single");

    tx_q = '{8'h55};
    xfer(8'h40, "t2_wrong_addr");

    tx_q = '{8'h12};
    xfer(8'h4F, "t3_read_nack");

    tx_q = '{8'h01, 8'h02, 8'h03};
    xfer(8'h4E, "t4_multi");

    // Partial byte cut short by a repeated START.
    rx_q.delete();
    i2c_start();
    write_byte(8'h4E, ack);
    check("t5.addr_ack1", ack, 1'b1);
    for (int i = 0; i < 4; i++) write_bit(1'($urandom_range(0, 1)));
    i2c_rstart();
    write_byte(8'h4E, ack);
    check("t5.addr_ack2", ack, 1'b1);
    write_byte(8'h3C, ack);
    check("t5.data_ack", ack, 1'b1);
    i2c_stop();
    #T;
    exp_rx_data = 8'h3C;
    check("t5.rx_count", rx_q.size(), 1);
    if (rx_q.size() > 0) check("t5.rx_byte", rx_q[0], 8'h3C);
    check("t5.rx_data", bus.rx_data, exp_rx_data);
    #T;

    // Asynchronous reset while the target holds the data ACK.
    i2c_start();
    write_byte(8'h4E, ack);
    check("t6.addr_ack", ack, 1'b1);
    b = 8'h96;
    for (int i = 7; i >= 0; i--) write_bit(b[i]);
    sda_m = 1'b1; #T;
    scl_m = 1'b1; #T;
    check("t6.sda_oe_in_ack", bus.sda_oe, 1'b1);
    check("t6.rx_data_captured", bus.rx_data, 8'h96);
    reset_p = 1'b1;
    #1;
    check("t6.rst_sda_oe", bus.sda_oe, 1'b0);
    check("t6.rst_busy", bus.busy, 1'b0);
    check("t6.rst_addr_match", bus.addr_match, 1'b0);
    check("t6.rst_rx_valid", bus.rx_valid, 1'b0);
    check("t6.rst_rx_data", bus.rx_data, 8'h00);
    exp_rx_data = 8'h00;
    #T;
    reset_p = 1'b0;
    #T;
    tx_q = '{8'($urandom)};
    xfer(8'h4E, "t6_after_reset");

    for (int n = 0; n < 6; n++) begin
      logic [7:0] addr;
      addr = ($urandom_range(0, 1) == 1) ? {SLAVE_ADDR, 1'b0} : 8'($urandom);
      tx_q.delete();
      for (int k = 0; k < int'($urandom_range(0, 3)); k++) tx_q.push_back(8'($urandom));
      xfer(addr, "rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
